rf_scoreboard: RTL and testbench
================================

# rf_scoreboard

Issue-side controller for the 32×32 register file of the pipelined CPU. Tracks destination registers owned by in-flight long-latency operations (multiply/divide unit), stalls dependent or conflicting instructions in ID, and arbitrates the register file's single write port between pipeline writeback and long-unit results. Sits between ID, WB, the long-latency unit and the register file write port (`RegWrite`/`Write_register`/`Write_data`).

## Interface
- `MAX_OUT`, default 4: maximum outstanding long-latency operations, legal range 1–15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `issue_valid`  in  1  ID holds an instruction requesting issue.
- `issue_rs`, `issue_rt`  in  5  source register numbers.
- `issue_use_rs`, `issue_use_rt`  in  1  source actually read.
- `issue_wr`  in  1  instruction writes a register.
- `issue_rd`  in  5  destination register.
- `issue_long`  in  1  destination produced by the long-latency unit.
- `issue_stall`  out  1  combinational; instruction must hold in ID.
- `wb_valid`  in  1  pipeline WB write request (never back-pressured).
- `wb_rd`  in  5  WB destination.
- `wb_data`  in  32  WB data.
- `lu_valid`  in  1  long unit presents a result.
- `lu_rd`  in  5  result destination.
- `lu_data`  in  32  result data.
- `lu_ready`  out  1  combinational; result accepted when `lu_valid && lu_ready`.
- `RegWrite`  out  1  register file write enable.
- `Write_register`  out  5  register file write address.
- `Write_data`  out  32  register file write data.
- `busy`  out  1  any long operation outstanding (`out_cnt != 0`).
- `err`  out  1  sticky protocol-error flag.

## Operation
- State: `pending[31:1]` bits (`$0` never pending), `out_cnt` (4 bits), one-entry hold register (`hold_valid`, `hold_rd`, `hold_data`), `err`.
- Stall, from registered state only: `issue_stall = issue_valid && (haz_rs || haz_rt || waw || full)`.
  - `haz_rs = issue_use_rs && pending[issue_rs]`; `haz_rt` likewise.
  - `waw = issue_wr && pending[issue_rd]`, applied to long and short writers.
  - `full = issue_wr && issue_long && out_cnt == MAX_OUT`.
- Accept: `issue_valid && !issue_stall`.
  - Accepted long op: `out_cnt += 1`; sets `pending[issue_rd]` if `issue_rd != 0`.
  - A long op targeting `$0` still counts as outstanding; its result is discarded.
- Write-port arbitration: WB has absolute priority.
  - `wb_valid`: `RegWrite = (wb_rd != 0)`, `Write_register = wb_rd`, `Write_data = wb_data`.
  - Else if `hold_valid`, the hold entry commits: `RegWrite = (hold_rd != 0)`, address/data from hold; clears `pending[hold_rd]`, `out_cnt -= 1`, `hold_valid <= 0`.
  - Else `RegWrite = 0`; address/data = 0.
- `lu_ready = !hold_valid || !wb_valid`, i.e. hold empty or draining this cycle.
  - Accepted result loads hold (`hold_valid <= 1`); same-cycle commit plus refill is legal.
- Simultaneous accept-long-issue and commit: `out_cnt` unchanged. Set and clear of the same register cannot coincide, because the WAW stall prevents it.
- `err` set (sticky until reset) on any of:
  - accepted `lu_valid` with `lu_rd != 0 && !pending[lu_rd]`;
  - `wb_valid` with `wb_rd != 0 && pending[wb_rd]`;
  - accepted result while `out_cnt == 0`.
- Error events do not alter `pending` or `out_cnt` beyond the normal rules.

## Timing
- Reset values: `pending = 0`, `out_cnt = 0`, `hold_valid = 0`, `hold_rd/data = 0`, `err = 0`.
  - Hence `issue_stall = 0`, `lu_ready = 1`, `RegWrite = 0`, `Write_register = 0`, `Write_data = 0`, `busy = 0`.
- Reset mid-operation discards all outstanding state and the hold entry. The long unit is reset by the same signal.
- Long issue accepted in cycle t: `pending` visible and `busy = 1` in t+1.
- Result accepted in cycle t with no WB conflict: RF written at end of t+1; `pending` clear visible in t+2; dependent issue accepted in t+2 at the earliest.
- Each WB cycle delays the hold commit by one cycle. Continuous `wb_valid` holds `lu_ready = 0` once hold is full.
- `RegWrite` and the write address/data are combinational from `wb_*` and the hold register; the register file samples them at the next rising edge.

## Test plan
- Long issue `rd = 8`, then next cycle `use_rs = 1, rs = 8` → `issue_stall = 1` until result accepted at t; stall drops in t+2; `Write_register = 8`, `Write_data = lu_data` in t+1.
- Hold full (`rd = 9`) with `wb_valid = 1`, `wb_rd = 3` for 3 cycles → WB writes `$3` each cycle, `lu_ready = 0`; hold commits `$9` in the first cycle with `wb_valid = 0`.
- Issue 4 long ops (`rd` 1–4) back-to-back with `MAX_OUT = 4` → fifth long issue stalls (`full`). A short op with `rd = 5` still issues. One commit releases the fifth next cycle.
- Short issue `rd = 6` while `pending[6]` → stalls (WAW). Long op with `rd = 0` → `out_cnt = 1`; result commits with `RegWrite = 0`; `busy` falls.
- Result with `lu_rd = 12` not pending → `err = 1` and stays 1. `reset` pulse mid-operation → all outputs at reset values next cycle, `err = 0`.
- Back-to-back results rd 10 then 11 with no WB → `lu_ready` stays 1; commits in consecutive cycles; `out_cnt` returns to 0.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Issue-side controller for the 32x32 register file. Tracks destination
// registers owned by in-flight long-latency operations, stalls dependent or
// conflicting instructions in ID, and arbitrates the single RF write port
// between pipeline writeback (always wins) and a one-entry long-unit hold
// register.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   issue_*                    ID instruction request; issue_stall out
//   wb_valid/wb_rd/wb_data     pipeline writeback request
//   lu_valid/lu_rd/lu_data     long-unit result; lu_ready out
//   RegWrite/Write_register/Write_data   register file write port
//   busy                       any long op outstanding
//   err                        sticky protocol-error flag
module rf_scoreboard #(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_use_rs,
  input  logic        issue_use_rt,
  input  logic        issue_wr,
  input  logic [4:0]  issue_rd,
  input  logic        issue_long,
  output logic        issue_stall,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [31:0] Write_data,
  output logic        busy,
  output logic        err
);

  logic [31:1] pending_q, pending_d;
  logic [3:0]  out_cnt_q, out_cnt_d;
  logic        hold_valid_q, hold_valid_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        err_q, err_d;

  // $0 is never pending; widening with a zero LSB lets every 5-bit register
  // number index the vector directly.
  logic [31:0] pend;
  assign pend = {pending_q, 1'b0};

  logic haz_rs, haz_rt, waw, full;
  logic accept_long, commit, lu_acc;

  always_comb begin
    haz_rs      = issue_use_rs && pend[issue_rs];
    haz_rt      = issue_use_rt && pend[issue_rt];
    waw         = issue_wr && pend[issue_rd];
    full        = issue_wr && issue_long && (out_cnt_q == 4'(MAX_OUT));
    issue_stall = issue_valid && (haz_rs || haz_rt || waw || full);
    accept_long = issue_valid && !issue_stall && issue_wr && issue_long;
    commit      = hold_valid_q && !wb_valid;
    lu_ready    = !hold_valid_q || !wb_valid;
    lu_acc      = lu_valid && lu_ready;
    busy        = (out_cnt_q != 4'd0);
    err         = err_q;
  end

  always_comb begin
    RegWrite       = 1'b0;
    Write_register = 5'd0;
    Write_data     = 32'd0;
    if (wb_valid) begin
      RegWrite       = (wb_rd != 5'd0);
      Write_register = wb_rd;
      Write_data     = wb_data;
    end else if (hold_valid_q) begin
      RegWrite       = (hold_rd_q != 5'd0);
      Write_register = hold_rd_q;
      Write_data     = hold_data_q;
    end
  end

  always_comb begin
    pending_d   = pending_q;
    out_cnt_d   = out_cnt_q;
    hold_valid_d = hold_valid_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    err_d       = err_q;

    // Clear before set: the WAW stall keeps both from hitting one register.
    if (commit && hold_rd_q != 5'd0) pending_d[hold_rd_q] = 1'b0;
    if (accept_long && issue_rd != 5'd0) pending_d[issue_rd] = 1'b1;

    // A commit of an erroneous (unowned) result must not underflow the count.
    if (accept_long && !(commit && out_cnt_q != 4'd0))
      out_cnt_d = out_cnt_q + 4'd1;
    else if (!accept_long && commit && out_cnt_q != 4'd0)
      out_cnt_d = out_cnt_q - 4'd1;

    if (lu_acc) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = lu_rd;
      hold_data_d  = lu_data;
    end else if (commit) begin
      hold_valid_d = 1'b0;
    end

    if (lu_acc && lu_rd != 5'd0 && !pend[lu_rd]) err_d = 1'b1;
    if (wb_valid && wb_rd != 5'd0 && pend[wb_rd]) err_d = 1'b1;
    if (lu_acc && out_cnt_q == 4'd0) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= '0;
      out_cnt_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      out_cnt_q    <= out_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_use_rs, issue_use_rt, issue_wr, issue_long;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        issue_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        busy, err;

  int total = 0;
  int bad = 0;

  rf_scoreboard #(.MAX_OUT(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_wr(issue_wr), .issue_rd(issue_rd), .issue_long(issue_long),
    .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_use_rs = 0; issue_use_rt = 0; issue_wr = 0;
    issue_long = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  task automatic long_issue(input logic [4:0] rd);
    issue_valid = 1; issue_wr = 1; issue_long = 1; issue_rd = rd;
    issue_use_rs = 0; issue_use_rt = 0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " stall"}, 32'(issue_stall), 0);
    check({tag, " lu_ready"}, 32'(lu_ready), 1);
    check({tag, " RegWrite"}, 32'(RegWrite), 0);
    check({tag, " Wreg"}, 32'(Write_register), 0);
    check({tag, " Wdata"}, Write_data, 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " err"}, 32'(err), 0);
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    check_reset_outs("rst");

    // RAW on a long result
    long_issue(5'd8); #1;
    check("raw accept", 32'(issue_stall), 0);
    tick();
    idle(); issue_valid = 1; issue_use_rs = 1; issue_rs = 8; #1;
    check("raw stall", 32'(issue_stall), 1);
    check("raw busy", 32'(busy), 1);
    tick();
    lu_valid = 1; lu_rd = 8; lu_data = 32'hDEAD_BEEF; #1;
    check("raw lu_ready", 32'(lu_ready), 1);
    check("raw stall t", 32'(issue_stall), 1);
    tick();
    lu_valid = 0; #1;
    check("raw RegWrite", 32'(RegWrite), 1);
    check("raw Wreg", 32'(Write_register), 8);
    check("raw Wdata", Write_data, 32'hDEAD_BEEF);
    check("raw stall t1", 32'(issue_stall), 1);
    tick(); #1;
    check("raw stall t2", 32'(issue_stall), 0);
    check("raw busy t2", 32'(busy), 0);
    tick(); idle();

    // Hold blocked by WB
    long_issue(5'd9); tick();
    idle(); lu_valid = 1; lu_rd = 9; lu_data = 32'h99; tick();
    idle(); wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("wb RegWrite", 32'(RegWrite), 1);
      check("wb Wreg", 32'(Write_register), 3);
      check("wb Wdata", Write_data, 32'h33);
      check("wb lu_ready", 32'(lu_ready), 0);
      tick();
    end
    wb_valid = 0; #1;
    check("hold RegWrite", 32'(RegWrite), 1);
    check("hold Wreg", 32'(Write_register), 9);
    check("hold Wdata", Write_data, 32'h99);
    tick(); #1;
    check("hold busy", 32'(busy), 0);
    check("hold err", 32'(err), 0);

    // Fill to MAX_OUT
    for (int r = 1; r <= 4; r++) begin
      long_issue(5'(r)); #1;
      check("fill accept", 32'(issue_stall), 0);
      tick();
    end
    long_issue(5'd7); #1;
    check("full stall", 32'(issue_stall), 1);
    tick();
    idle(); issue_valid = 1; issue_wr = 1; issue_rd = 5; #1;
    check("full short", 32'(issue_stall), 0);
    tick();
    long_issue(5'd7); lu_valid = 1; lu_rd = 1; lu_data = 32'h11; #1;
    check("full stall2", 32'(issue_stall), 1);
    tick();
    lu_valid = 0; #1;
    check("full commit reg", 32'(Write_register), 1);
    check("full stall3", 32'(issue_stall), 1);
    tick(); #1;
    check("full release", 32'(issue_stall), 0);
    tick();
    idle();
    begin
      logic [4:0] rds [4];
      rds[0] = 2; rds[1] = 3; rds[2] = 4; rds[3] = 7;
      for (int i = 0; i < 4; i++) begin
        lu_valid = 1; lu_rd = rds[i]; lu_data = 32'(rds[i]) + 32'h100; #1;
        check("drain lu_ready", 32'(lu_ready), 1);
        if (i > 0) check("drain Wreg", 32'(Write_register), 32'(rds[i-1]));
        tick();
      end
    end
    lu_valid = 0; #1;
    check("drain last Wdata", Write_data, 32'h107);
    tick(); #1;
    check("drain busy", 32'(busy), 0);
    check("drain err", 32'(err), 0);

    // WAW and long to $0
    long_issue(5'd6); tick();
    idle(); issue_valid = 1; issue_wr = 1; issue_rd = 6; #1;
    check("waw stall", 32'(issue_stall), 1);
    idle(); lu_valid = 1; lu_rd = 6; lu_data = 32'h66; tick();
    idle(); tick();
    long_issue(5'd0); tick();
    idle(); #1;
    check("r0 busy", 32'(busy), 1);
    lu_valid = 1; lu_rd = 0; lu_data = 32'h55; tick();
    lu_valid = 0; #1;
    check("r0 RegWrite", 32'(RegWrite), 0);
    check("r0 busy hold", 32'(busy), 1);
    tick(); #1;
    check("r0 busy fall", 32'(busy), 0);
    check("r0 err", 32'(err), 0);

    // Back-to-back results
    long_issue(5'd10); tick();
    long_issue(5'd11); tick();
    idle(); lu_valid = 1; lu_rd = 10; lu_data = 32'hA0; #1;
    check("b2b ready0", 32'(lu_ready), 1);
    tick();
    lu_rd = 11; lu_data = 32'hB0; #1;
    check("b2b ready1", 32'(lu_ready), 1);
    check("b2b Wreg10", 32'(Write_register), 10);
    tick();
    lu_valid = 0; #1;
    check("b2b Wreg11", 32'(Write_register), 11);
    check("b2b Wdata11", Write_data, 32'hB0);
    tick(); #1;
    check("b2b busy", 32'(busy), 0);

    // Unowned result sets sticky err; reset clears everything
    lu_valid = 1; lu_rd = 12; lu_data = 32'hC0; tick();
    lu_valid = 0; #1;
    check("err set", 32'(err), 1);
    tick(); tick(); #1;
    check("err sticky", 32'(err), 1);
    long_issue(5'd13); tick();
    idle(); lu_valid = 1; lu_rd = 13; lu_data = 32'hD0; tick();
    idle(); reset = 1; tick();
    reset = 0; #1;
    check_reset_outs("midrst");
    issue_valid = 1; issue_use_rs = 1; issue_rs = 13; #1;
    check("midrst pend13", 32'(issue_stall), 0);
    idle(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
